program_counter7: RTL and testbench
===================================

Name: program_counter7

Overview:
- 7-bit program counter stage that drives the operand inputs of the 7-bit carry-look-ahead adder and consumes its sum to form the next PC.
- Selects between increment, PC-relative branch, absolute jump, and (optionally) call/return.
- Includes a small run/halt controller.
- Sits between the instruction decoder (which supplies OP/BR_VAL) and the instruction memory address port.

Parameters:
RESET_VEC, 7'd0, PC value loaded on reset
STACK_DEPTH, 4, return-stack entries (only used with RET_STACK_EN; legal 2..8)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
EN  input  1  advance PC this cycle (RUN state only)
OP  input  3  000 INC, 001 BRREL, 010 JMP, 011 CALL, 100 RET, others treated as INC
BR_VAL  input  7  branch offset (two's complement) or absolute target
HALT  input  1  request halt
RESUME  input  1  leave HALTED
ADD_A  output  7  adder operand A
ADD_B  output  7  adder operand B
ADD_CIN  output  1  adder carry-in
ADD_R  input  7  adder sum, combinational return from adder
PC  output  7  current program counter (registered)
PC_VALID  output  1  high when PC is a fetchable address
STK_ERR  output  1  sticky return-stack over/underflow flag

Behaviour:
- Reset (RESET=1 at edge): PC=RESET_VEC, state=BOOT, PC_VALID=0, STK_ERR=0, stack emptied. Reset wins over every other input, including mid-halt and mid-call.
- FSM states:
  - BOOT -> RUN on the first edge with RESET=0.
  - RUN -> HALTED on an edge with HALT=1.
  - HALTED -> RUN on an edge with RESUME=1 and HALT=0.
  - HALT has priority over RESUME.
- PC_VALID: registered; 1 in RUN, 0 in BOOT and HALTED.
- Adder drive (combinational, always driven): ADD_A=PC. ADD_B=BR_VAL when OP=BRREL, else 0. ADD_CIN=1.
  - So ADD_R = PC+1 (INC), or PC+1+BR_VAL (BRREL).
- PC update only when state=RUN, EN=1, HALT=0. Next PC by OP:
  - INC: PC<=ADD_R.
  - BRREL: PC<=ADD_R.
  - JMP: PC<=BR_VAL.
  - CALL: PC<=BR_VAL, push PC+1 (the ADD_R value computed with ADD_B=0).
  - RET: PC<=top of stack, pop.
- When CALL is selected, ADD_B=0, so ADD_R is the return address.
- Wrap-around: arithmetic is mod 128, with no carry out. 7'd127 INC -> 7'd0. PC=5, BR_VAL=7'h7E (-2) -> 4.
- EN=0 or not in RUN: PC holds, stack unchanged.
- Latency: OP/BR_VAL sampled at edge N; new PC visible after edge N. One-cycle update, no bubbles.
- HALT and EN both high in the same cycle: no update, enter HALTED.

Optional Feature:
- Macro RET_STACK_EN.
- When defined:
  - STACK_DEPTH-entry LIFO of 7-bit return addresses, with a pointer/count.
  - CALL with stack full: push still happens, oldest entry discarded (circular), STK_ERR<=1.
  - RET with stack empty: behaves as INC, STK_ERR<=1.
  - STK_ERR is sticky until RESET.
- When not defined:
  - No stack storage.
  - CALL behaves exactly as JMP; RET behaves exactly as INC.
  - STK_ERR tied 0.

Test Plan:
- RESET=1 for 2 cycles, RESET_VEC=7'd10 -> PC=10, PC_VALID=0; first edge after release PC_VALID=1, PC=10; with EN=1, OP=INC for 3 edges -> PC=11,12,13.
- PC=127, OP=INC, EN=1 -> PC=0. PC=5, OP=BRREL, BR_VAL=7'h7E -> PC=4, and at that cycle ADD_A=5, ADD_B=7'h7E, ADD_CIN=1.
- PC=20, OP=JMP, BR_VAL=90 -> PC=90. EN=0 for 3 cycles with OP=JMP -> PC stays 90.
- PC=30, HALT=1 with EN=1, OP=INC -> PC stays 30, PC_VALID=0. RESUME=1 -> PC_VALID=1, then INC gives 31. HALT and RESUME together -> remain HALTED.
- With RET_STACK_EN, STACK_DEPTH=4:
  - PC=8, CALL to 40 -> PC=40. Then RET -> PC=9.
  - 5 nested CALLs -> STK_ERR=1, last 4 return addresses popped in LIFO order.
  - A further RET on empty stack -> PC+1.
- Without RET_STACK_EN: PC=8, CALL to 40 -> PC=40; RET -> PC=41; STK_ERR stays 0. RESET asserted mid-sequence -> PC=RESET_VEC, STK_ERR=0.

Source files
------------

// File: rtl/program_counter7.sv
// 7-bit program counter with run/halt control; drives an external CLA adder and consumes its sum.
// Optional return stack: define RET_STACK_EN to enable CALL/RET with a STACK_DEPTH-entry LIFO.
module program_counter7 #(
   parameter logic [6:0] RESET_VEC   = 7'd0,
   parameter int         STACK_DEPTH = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       EN,
   input  logic [2:0] OP,
   input  logic [6:0] BR_VAL,
   input  logic       HALT,
   input  logic       RESUME,
   output logic [6:0] ADD_A,
   output logic [6:0] ADD_B,
   output logic       ADD_CIN,
   input  logic [6:0] ADD_R,
   output logic [6:0] PC,
   output logic       PC_VALID,
   output logic       STK_ERR
);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   localparam logic [2:0] OP_INC   = 3'b000;
   localparam logic [2:0] OP_BRREL = 3'b001;
   localparam logic [2:0] OP_JMP   = 3'b010;
   localparam logic [2:0] OP_CALL  = 3'b011;
   localparam logic [2:0] OP_RET   = 3'b100;

   if (STACK_DEPTH < 2 || STACK_DEPTH > 8) begin : g_bad_depth
      $error("program_counter7: STACK_DEPTH must be in 2..8");
   end

   state_t     state_q, state_d;
   logic [6:0] pc_q, pc_d;
   logic       pc_valid_q, pc_valid_d;
   logic       advance;

   // Carry-in is tied high so the adder sum is always PC+1(+offset); CALL sees ADD_B=0.
   assign ADD_A   = pc_q;
   assign ADD_B   = (OP == OP_BRREL) ? BR_VAL : 7'd0;
   assign ADD_CIN = 1'b1;

   assign PC       = pc_q;
   assign PC_VALID = pc_valid_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT:   state_d = ST_RUN;
         ST_RUN:    if (HALT) state_d = ST_HALTED;
         ST_HALTED: if (RESUME && !HALT) state_d = ST_RUN;
         default:   state_d = ST_BOOT;
      endcase
      pc_valid_d = (state_d == ST_RUN);
   end

   assign advance = (state_q == ST_RUN) && EN && !HALT;

`ifdef RET_STACK_EN
   localparam int PTR_W = $clog2(STACK_DEPTH);
   localparam int CNT_W = $clog2(STACK_DEPTH + 1);

   // Circular LIFO: stk_ptr_q is the next slot to write; a full push overwrites the oldest entry.
   logic [6:0]       stk_mem_q [STACK_DEPTH];
   logic [PTR_W-1:0] stk_ptr_q, stk_ptr_d;
   logic [CNT_W-1:0] stk_cnt_q, stk_cnt_d;
   logic             stk_err_q, stk_err_d;
   logic             stk_push;
   logic [PTR_W-1:0] ptr_inc, ptr_dec;
   logic [6:0]       stk_top;

   assign ptr_inc = (stk_ptr_q == PTR_W'(STACK_DEPTH - 1)) ? '0 : stk_ptr_q + 1'b1;
   assign ptr_dec = (stk_ptr_q == '0) ? PTR_W'(STACK_DEPTH - 1) : stk_ptr_q - 1'b1;
   assign stk_top = stk_mem_q[ptr_dec];
   assign STK_ERR = stk_err_q;
`else
   assign STK_ERR = 1'b0;
`endif

   always_comb begin
      pc_d = pc_q;
`ifdef RET_STACK_EN
      stk_ptr_d = stk_ptr_q;
      stk_cnt_d = stk_cnt_q;
      stk_err_d = stk_err_q;
      stk_push  = 1'b0;
`endif
      if (advance) begin
         case (OP)
            OP_JMP: pc_d = BR_VAL;
`ifdef RET_STACK_EN
            OP_CALL: begin
               pc_d      = BR_VAL;
               stk_push  = 1'b1;
               stk_ptr_d = ptr_inc;
               if (stk_cnt_q == CNT_W'(STACK_DEPTH)) begin
                  stk_err_d = 1'b1;
               end else begin
                  stk_cnt_d = stk_cnt_q + 1'b1;
               end
            end
            OP_RET: begin
               if (stk_cnt_q == '0) begin
                  pc_d      = ADD_R;
                  stk_err_d = 1'b1;
               end else begin
                  pc_d      = stk_top;
                  stk_ptr_d = ptr_dec;
                  stk_cnt_d = stk_cnt_q - 1'b1;
               end
            end
`else
            OP_CALL: pc_d = BR_VAL;
            OP_RET:  pc_d = ADD_R;
`endif
            default: pc_d = ADD_R;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VEC;
         pc_valid_q <= 1'b0;
`ifdef RET_STACK_EN
         stk_ptr_q  <= '0;
         stk_cnt_q  <= '0;
         stk_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
`ifdef RET_STACK_EN
         stk_ptr_q  <= stk_ptr_d;
         stk_cnt_q  <= stk_cnt_d;
         stk_err_q  <= stk_err_d;
`endif
      end
   end

`ifdef RET_STACK_EN
   // Entry storage carries no reset; the count alone decides what is valid.
   always_ff @(posedge CLK) begin
      if (stk_push && !RESET) begin
         stk_mem_q[stk_ptr_q] <= ADD_R;
      end
   end
`endif

endmodule

// File: tb/tb_program_counter7.sv
// Directed bench for program_counter7 with RESET_VEC=10, STACK_DEPTH=4 and a behavioural adder.
module tb_program_counter7;

   localparam logic [2:0] OP_INC   = 3'b000;
   localparam logic [2:0] OP_BRREL = 3'b001;
   localparam logic [2:0] OP_JMP   = 3'b010;
   localparam logic [2:0] OP_CALL  = 3'b011;
   localparam logic [2:0] OP_RET   = 3'b100;

   logic       CLK = 1'b0;
   logic       RESET, EN, HALT, RESUME;
   logic [2:0] OP;
   logic [6:0] BR_VAL;
   logic [6:0] ADD_A, ADD_B, ADD_R, PC;
   logic       ADD_CIN, PC_VALID, STK_ERR;

   int errors = 0;
   int checks = 0;

   program_counter7 #(.RESET_VEC(7'd10), .STACK_DEPTH(4)) dut (
      .CLK(CLK), .RESET(RESET), .EN(EN), .OP(OP), .BR_VAL(BR_VAL),
      .HALT(HALT), .RESUME(RESUME), .ADD_A(ADD_A), .ADD_B(ADD_B),
      .ADD_CIN(ADD_CIN), .ADD_R(ADD_R), .PC(PC), .PC_VALID(PC_VALID),
      .STK_ERR(STK_ERR)
   );

   // External adder: mod-128 sum, carry-out dropped.
   assign ADD_R = ADD_A + ADD_B + {6'd0, ADD_CIN};

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1; EN = 1'b1; OP = OP_INC; BR_VAL = 7'd0; HALT = 1'b0; RESUME = 1'b0;
      tick(); tick();
      checks++; if (PC !== 7'd10) begin errors++; $display("FAIL reset_pc: got %0d expected 10", PC); end
      checks++; if (PC_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", PC_VALID); end
      checks++; if (STK_ERR !== 1'b0) begin errors++; $display("FAIL reset_stkerr: got %b expected 0", STK_ERR); end
      checks++; if (ADD_A !== 7'd10 || ADD_B !== 7'd0 || ADD_CIN !== 1'b1) begin
         errors++; $display("FAIL reset_adder: got A=%0d B=%0d CIN=%b expected A=10 B=0 CIN=1", ADD_A, ADD_B, ADD_CIN);
      end
      RESET = 1'b0; EN = 1'b0;
      tick();
      checks++; if (PC_VALID !== 1'b1 || PC !== 7'd10) begin
         errors++; $display("FAIL boot_exit: got valid=%b pc=%0d expected valid=1 pc=10", PC_VALID, PC);
      end
      EN = 1'b1; OP = OP_INC;
      for (int i = 0; i < 3; i++) begin
         logic [6:0] exp;
         exp = 7'd11 + 7'(i);
         tick();
         checks++; if (PC !== exp) begin errors++; $display("FAIL inc_seq%0d: got %0d expected %0d", i, PC, exp); end
      end
   endtask

   task automatic test_wrap_branch();
      OP = OP_JMP; BR_VAL = 7'd127; tick();
      checks++; if (PC !== 7'd127) begin errors++; $display("FAIL jmp127: got %0d expected 127", PC); end
      OP = OP_INC; tick();
      checks++; if (PC !== 7'd0) begin errors++; $display("FAIL inc_wrap: got %0d expected 0", PC); end
      OP = OP_JMP; BR_VAL = 7'd5; tick();
      OP = OP_BRREL; BR_VAL = 7'h7E; #1;
      checks++; if (ADD_A !== 7'd5 || ADD_B !== 7'h7E || ADD_CIN !== 1'b1) begin
         errors++; $display("FAIL brrel_adder: got A=%0d B=%h CIN=%b expected A=5 B=7e CIN=1", ADD_A, ADD_B, ADD_CIN);
      end
      tick();
      checks++; if (PC !== 7'd4) begin errors++; $display("FAIL brrel_neg: got %0d expected 4", PC); end
      BR_VAL = 7'd10; tick();
      checks++; if (PC !== 7'd15) begin errors++; $display("FAIL brrel_pos: got %0d expected 15", PC); end
   endtask

   task automatic test_jmp_hold();
      OP = OP_JMP; BR_VAL = 7'd20; tick();
      checks++; if (PC !== 7'd20) begin errors++; $display("FAIL jmp20: got %0d expected 20", PC); end
      BR_VAL = 7'd90; tick();
      checks++; if (PC !== 7'd90) begin errors++; $display("FAIL jmp90: got %0d expected 90", PC); end
      EN = 1'b0; BR_VAL = 7'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (PC !== 7'd90) begin errors++; $display("FAIL en_hold%0d: got %0d expected 90", i, PC); end
      end
      EN = 1'b1; OP = 3'b111; tick();
      checks++; if (PC !== 7'd91) begin errors++; $display("FAIL op_other_inc: got %0d expected 91", PC); end
   endtask

   task automatic test_halt();
      OP = OP_JMP; BR_VAL = 7'd30; tick();
      HALT = 1'b1; OP = OP_INC; tick();
      checks++; if (PC !== 7'd30 || PC_VALID !== 1'b0) begin
         errors++; $display("FAIL halt_enter: got pc=%0d valid=%b expected pc=30 valid=0", PC, PC_VALID);
      end
      HALT = 1'b0; RESUME = 1'b1; EN = 1'b0; tick();
      checks++; if (PC !== 7'd30 || PC_VALID !== 1'b1) begin
         errors++; $display("FAIL resume: got pc=%0d valid=%b expected pc=30 valid=1", PC, PC_VALID);
      end
      RESUME = 1'b0; EN = 1'b1; tick();
      checks++; if (PC !== 7'd31) begin errors++; $display("FAIL inc_after_resume: got %0d expected 31", PC); end
      HALT = 1'b1; tick();
      HALT = 1'b1; RESUME = 1'b1; tick();
      checks++; if (PC !== 7'd31 || PC_VALID !== 1'b0) begin
         errors++; $display("FAIL halt_resume_both: got pc=%0d valid=%b expected pc=31 valid=0", PC, PC_VALID);
      end
      HALT = 1'b0; RESUME = 1'b0; tick();
      checks++; if (PC !== 7'd31 || PC_VALID !== 1'b0) begin
         errors++; $display("FAIL halted_en_ignored: got pc=%0d valid=%b expected pc=31 valid=0", PC, PC_VALID);
      end
      RESUME = 1'b1; tick();
      checks++; if (PC !== 7'd31 || PC_VALID !== 1'b1) begin
         errors++; $display("FAIL resume2: got pc=%0d valid=%b expected pc=31 valid=1", PC, PC_VALID);
      end
      RESUME = 1'b0; tick();
      checks++; if (PC !== 7'd32) begin errors++; $display("FAIL inc_after_resume2: got %0d expected 32", PC); end
   endtask

   task automatic test_call_ret();
      logic [6:0] exp_ret;
`ifdef RET_STACK_EN
      exp_ret = 7'd9;
`else
      exp_ret = 7'd41;
`endif
      OP = OP_JMP; BR_VAL = 7'd8; tick();
      OP = OP_CALL; BR_VAL = 7'd40; #1;
      checks++; if (ADD_B !== 7'd0 || ADD_R !== 7'd9) begin
         errors++; $display("FAIL call_adder: got B=%0d R=%0d expected B=0 R=9", ADD_B, ADD_R);
      end
      tick();
      checks++; if (PC !== 7'd40) begin errors++; $display("FAIL call_target: got %0d expected 40", PC); end
      OP = OP_RET; tick();
      checks++; if (PC !== exp_ret) begin errors++; $display("FAIL ret: got %0d expected %0d", PC, exp_ret); end
      checks++; if (STK_ERR !== 1'b0) begin errors++; $display("FAIL ret_stkerr: got %b expected 0", STK_ERR); end
   endtask

`ifdef RET_STACK_EN
   task automatic test_stack_overflow();
      logic [6:0] exp;
      OP = OP_JMP; BR_VAL = 7'd0; tick();
      for (int i = 0; i < 5; i++) begin
         OP = OP_CALL; BR_VAL = 7'(10 * (i + 1)); tick();
         checks++; if (PC !== BR_VAL) begin errors++; $display("FAIL ncall%0d: got %0d expected %0d", i, PC, BR_VAL); end
         checks++; if (STK_ERR !== (i == 4)) begin
            errors++; $display("FAIL ncall_err%0d: got %b expected %b", i, STK_ERR, (i == 4));
         end
      end
      OP = OP_RET;
      for (int i = 0; i < 4; i++) begin
         exp = 7'(41 - 10 * i);
         tick();
         checks++; if (PC !== exp) begin errors++; $display("FAIL nret%0d: got %0d expected %0d", i, PC, exp); end
      end
      tick();
      checks++; if (PC !== 7'd12 || STK_ERR !== 1'b1) begin
         errors++; $display("FAIL ret_empty: got pc=%0d err=%b expected pc=12 err=1", PC, STK_ERR);
      end
   endtask
`endif

   task automatic test_reset_mid();
      logic exp_err;
`ifdef RET_STACK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      OP = OP_CALL; BR_VAL = 7'd60; tick();
      RESET = 1'b1; HALT = 1'b1; BR_VAL = 7'd70; tick();
      checks++; if (PC !== 7'd10 || PC_VALID !== 1'b0 || STK_ERR !== 1'b0) begin
         errors++; $display("FAIL reset_mid: got pc=%0d valid=%b err=%b expected pc=10 valid=0 err=0", PC, PC_VALID, STK_ERR);
      end
      RESET = 1'b0; HALT = 1'b0; OP = OP_RET; tick();
      checks++; if (PC !== 7'd10 || PC_VALID !== 1'b1) begin
         errors++; $display("FAIL reset_mid_boot: got pc=%0d valid=%b expected pc=10 valid=1", PC, PC_VALID);
      end
      tick();
      checks++; if (PC !== 7'd11 || STK_ERR !== exp_err) begin
         errors++; $display("FAIL ret_after_reset: got pc=%0d err=%b expected pc=11 err=%b", PC, STK_ERR, exp_err);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_wrap_branch();
      test_jmp_hold();
      test_halt();
      test_call_ret();
`ifdef RET_STACK_EN
      test_stack_overflow();
`endif
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
